sata_dev_link_responder: RTL and testbench

SATA_DEV_LINK_RESPONDER -- requirements
Module: sata_dev_link_responder

---
 rtl/sata_link_pkg.sv | 46 ++++
 rtl/sata_crc32.sv | 25 ++
 rtl/sata_dev_link_responder.sv | 192 +++++++++++++++++++
 tb/tb_sata_dev_link_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_link_pkg.sv
// Shared SATA link-layer constants: primitive codes, CRC parameters, responder state encoding,
// and the 32-bit-per-cycle CRC step.
package sata_link_pkg;

  localparam logic [31:0] PrimAlign = 32'h7B4A4ABC;
  localparam logic [31:0] PrimSync  = 32'hB5B5957C;
  localparam logic [31:0] PrimXRdy  = 32'h5757B57C;
  localparam logic [31:0] PrimRRdy  = 32'h4A4A957C;
  localparam logic [31:0] PrimSof   = 32'h3737B57C;
  localparam logic [31:0] PrimEof   = 32'hD5D5B57C;
  localparam logic [31:0] PrimRIp   = 32'h5555B57C;
  localparam logic [31:0] PrimROk   = 32'h3535B57C;
  localparam logic [31:0] PrimRErr  = 32'h5656B57C;
  localparam logic [31:0] PrimWtrm  = 32'h5858B57C;
  localparam logic [31:0] PrimHold  = 32'hD5D5AA7C;
  localparam logic [31:0] PrimHolda = 32'h9595AA7C;
  localparam logic [31:0] PrimCont  = 32'h9999AA7C;

  localparam logic [31:0] CrcPoly = 32'h04C11DB7;
  localparam logic [31:0] CrcInit = 32'h52325032;

  typedef enum logic [2:0] {
    StIdle,
    StRdy,
    StRcv,
    StHoldTx,
    StHoldaTx,
    StChk,
    StResp
  } link_state_e;

  // MSB-first, one data bit per iteration, no reflection or final inversion.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) begin
        c = {c[30:0], 1'b0} ^ CrcPoly;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_crc32.sv
// Running SATA CRC-32 over one dword per enabled cycle; clear reloads the seed.
module sata_crc32
  import sata_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] crc
);

  logic [31:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= CrcInit;
    end else if (en) begin
      crc_q <= crc32_step(crc_q, din);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sata_dev_link_responder.sv
// Device-side SATA link receiver: answers host X_RDY, receives one frame, streams payload out
// with back-pressure, checks CRC and length, then returns R_OK or R_ERR.
module sata_dev_link_responder
  import sata_link_pkg::*;
#(
  parameter int unsigned MAX_DW = 2049
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_charisk,
  output logic [31:0] tx_data,
  output logic        tx_charisk,
  output logic [31:0] pl_data,
  output logic        pl_valid,
  input  logic        pl_ready,
  output logic        frame_done,
  output logic        frame_ok
);

  localparam logic [11:0] MaxDwC = 12'(MAX_DW);

  link_state_e state_q;
  logic [31:0] stage_q;
  logic        stage_valid_q;
  logic [31:0] skid_q;
  logic        skid_valid_q;
  logic [11:0] cnt_q;

  logic        rx_prim, rx_is_data, rx_drop;
  logic        rx_sync, rx_xrdy, rx_sof, rx_eof, rx_hold;
  logic        stalled, release_en, emit, crc_clr, frame_good;
  logic [31:0] next_stage, crc_val;
  logic [11:0] cnt_inc;

  assign rx_prim    = (rx_charisk == 4'b0001);
  assign rx_is_data = !rx_prim;
  assign rx_drop    = rx_prim && ((rx_data == PrimAlign) || (rx_data == PrimCont));
  assign rx_sync    = rx_prim && (rx_data == PrimSync);
  assign rx_xrdy    = rx_prim && (rx_data == PrimXRdy);
  assign rx_sof     = rx_prim && (rx_data == PrimSof);
  assign rx_eof     = rx_prim && (rx_data == PrimEof);
  assign rx_hold    = rx_prim && (rx_data == PrimHold);

  assign stalled    = pl_valid && !pl_ready;
  assign tx_charisk = 1'b1;

  // A release pushes the staged dword downstream and folds it into the CRC; the staged dword
  // that is never released (the one held at EOF) is the received CRC.
  always_comb begin
    release_en = 1'b0;
    case (state_q)
      StRcv, StHoldaTx: release_en = rx_is_data && stage_valid_q && !stalled;
      StHoldTx:         release_en = pl_ready && !rx_sync && (skid_valid_q || rx_is_data);
      default:          release_en = 1'b0;
    endcase
  end

  assign next_stage = skid_valid_q ? skid_q : rx_data;
  assign emit       = release_en && (cnt_q < MaxDwC);
  assign cnt_inc    = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
  assign crc_clr    = (state_q == StRdy) && rx_sof;
  assign frame_good = stage_valid_q && (crc_val == stage_q) &&
                      (cnt_q != 12'd0) && (cnt_q <= MaxDwC);

  sata_crc32 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (release_en),
    .din (stage_q),
    .crc (crc_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      tx_data       <= PrimSync;
      pl_data       <= 32'h0;
      pl_valid      <= 1'b0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      stage_q       <= 32'h0;
      stage_valid_q <= 1'b0;
      skid_q        <= 32'h0;
      skid_valid_q  <= 1'b0;
      cnt_q         <= 12'd0;
    end else begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      if (pl_valid && pl_ready) pl_valid <= 1'b0;

      if (release_en) begin
        cnt_q        <= cnt_inc;
        stage_q      <= next_stage;
        skid_valid_q <= 1'b0;
        if (emit) begin
          pl_data  <= stage_q;
          pl_valid <= 1'b1;
        end
      end

      case (state_q)
        StIdle: begin
          if (rx_xrdy) begin
            state_q <= StRdy;
            tx_data <= PrimRRdy;
          end
        end
        StRdy: begin
          if (rx_sof) begin
            state_q       <= StRcv;
            tx_data       <= PrimRIp;
            cnt_q         <= 12'd0;
            stage_q       <= 32'h0;
            stage_valid_q <= 1'b0;
            skid_valid_q  <= 1'b0;
          end else if (rx_sync) begin
            state_q <= StIdle;
            tx_data <= PrimSync;
          end
        end
        StRcv, StHoldaTx: begin
          if (rx_sync) begin
            state_q    <= StIdle;
            tx_data    <= PrimSync;
            pl_valid   <= 1'b0;
            frame_done <= 1'b1;
          end else if (rx_eof) begin
            state_q <= StChk;
            tx_data <= PrimRIp;
          end else if (rx_is_data) begin
            if (stage_valid_q && stalled) begin
              // No room downstream: park the new dword and ask the host to pause.
              skid_q       <= rx_data;
              skid_valid_q <= 1'b1;
              state_q      <= StHoldTx;
              tx_data      <= PrimHold;
            end else begin
              if (!stage_valid_q) begin
                stage_q       <= rx_data;
                stage_valid_q <= 1'b1;
              end
              state_q <= StRcv;
              tx_data <= PrimRIp;
            end
          end else if ((state_q == StRcv) && stalled) begin
            state_q <= StHoldTx;
            tx_data <= PrimHold;
          end else if (rx_hold) begin
            state_q <= StHoldaTx;
            tx_data <= PrimHolda;
          end else if ((state_q == StHoldaTx) && rx_prim && !rx_drop) begin
            state_q <= StRcv;
            tx_data <= PrimRIp;
          end
        end
        StHoldTx: begin
          if (rx_sync) begin
            state_q    <= StIdle;
            tx_data    <= PrimSync;
            pl_valid   <= 1'b0;
            frame_done <= 1'b1;
          end else if (pl_ready) begin
            state_q <= StRcv;
            tx_data <= PrimRIp;
          end else if (rx_is_data && !skid_valid_q) begin
            skid_q       <= rx_data;
            skid_valid_q <= 1'b1;
          end
        end
        StChk: begin
          state_q    <= StResp;
          frame_done <= 1'b1;
          frame_ok   <= frame_good;
          tx_data    <= frame_good ? PrimROk : PrimRErr;
        end
        StResp: begin
          if (rx_sync) begin
            state_q <= StIdle;
            tx_data <= PrimSync;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_data <= PrimSync;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sata_dev_link_responder.sv
// Directed bench for the device link responder: good/bad CRC, back-pressure, host hold,
// length overflow, empty frame, host abort and mid-frame reset.
module tb_sata_dev_link_responder;

  localparam logic [31:0] PAlign = 32'h7B4A4ABC;
  localparam logic [31:0] PSync  = 32'hB5B5957C;
  localparam logic [31:0] PXRdy  = 32'h5757B57C;
  localparam logic [31:0] PRRdy  = 32'h4A4A957C;
  localparam logic [31:0] PSof   = 32'h3737B57C;
  localparam logic [31:0] PEof   = 32'hD5D5B57C;
  localparam logic [31:0] PRIp   = 32'h5555B57C;
  localparam logic [31:0] PROk   = 32'h3535B57C;
  localparam logic [31:0] PRErr  = 32'h5656B57C;
  localparam logic [31:0] PWtrm  = 32'h5858B57C;
  localparam logic [31:0] PHold  = 32'hD5D5AA7C;
  localparam logic [31:0] PHolda = 32'h9595AA7C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_data;
  logic [3:0]  rx_charisk;
  logic        pl_ready;
  logic [31:0] tx_data0, pl_data0, tx_data4, pl_data4;
  logic        tx_k0, pl_valid0, fdone0, fok0, tx_k4, pl_valid4, fdone4, fok4;

  int checks = 0;
  int failures = 0;
  logic [31:0] got0[$];
  logic [31:0] got4[$];

  always #5 clk = ~clk;

  sata_dev_link_responder u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_charisk(rx_charisk),
    .tx_data(tx_data0), .tx_charisk(tx_k0), .pl_data(pl_data0), .pl_valid(pl_valid0),
    .pl_ready(pl_ready), .frame_done(fdone0), .frame_ok(fok0)
  );

  sata_dev_link_responder #(.MAX_DW(4)) u_dut4 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_charisk(rx_charisk),
    .tx_data(tx_data4), .tx_charisk(tx_k4), .pl_data(pl_data4), .pl_valid(pl_valid4),
    .pl_ready(pl_ready), .frame_done(fdone4), .frame_ok(fok4)
  );

  // Inputs settle at the falling edge; log every dword the sink accepts on the next rise.
  always @(negedge clk) begin
    #2;
    if (!rst && pl_valid0 && pl_ready) got0.push_back(pl_data0);
    if (!rst && pl_valid4 && pl_ready) got4.push_back(pl_data4);
  end

  // XOR the dword into the register, then 32 polynomial shifts.
  function automatic logic [31:0] crc_add(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 32; i++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    return c;
  endfunction

  task automatic step(input logic [31:0] d, input logic k);
    rx_data    = d;
    rx_charisk = k ? 4'b0001 : 4'b0000;
    @(negedge clk);
  endtask

  task automatic frame_start();
    step(PXRdy, 1'b1);
    step(PSof, 1'b1);
    got0.delete();
    got4.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pl_ready = 1'b1;
    step(PSync, 1'b1);
    step(PSync, 1'b1);
    checks++; if (tx_data0 !== PSync) begin failures++; $display("FAIL reset_tx: got %h want %h", tx_data0, PSync); end
    checks++; if (tx_k0 !== 1'b1) begin failures++; $display("FAIL reset_txk: got %b want 1", tx_k0); end
    checks++; if (pl_valid0 !== 1'b0 || pl_data0 !== 32'h0) begin failures++; $display("FAIL reset_pl: got v=%b d=%h want v=0 d=0", pl_valid0, pl_data0); end
    checks++; if (fdone0 !== 1'b0 || fok0 !== 1'b0) begin failures++; $display("FAIL reset_frame: got done=%b ok=%b want 0 0", fdone0, fok0); end
    rst = 1'b0;
    step(PSync, 1'b1);
  endtask

  task automatic run_small_frame(input logic flip, input string tag);
    logic [31:0] crc;
    crc = crc_add(crc_add(32'h52325032, 32'h00000027), 32'h00000000) ^ {31'h0, flip};
    for (int i = 0; i < 4; i++) begin
      step(PXRdy, 1'b1);
      checks++; if (tx_data0 !== PRRdy) begin failures++; $display("FAIL %s_rrdy: got %h want %h", tag, tx_data0, PRRdy); end
    end
    step(PSof, 1'b1);
    checks++; if (tx_data0 !== PRIp) begin failures++; $display("FAIL %s_rip: got %h want %h", tag, tx_data0, PRIp); end
    step(32'h00000027, 1'b0);
    checks++; if (pl_valid0 !== 1'b0) begin failures++; $display("FAIL %s_staged: got v=%b want 0", tag, pl_valid0); end
    step(32'h00000000, 1'b0);
    checks++; if (pl_valid0 !== 1'b1 || pl_data0 !== 32'h27) begin failures++; $display("FAIL %s_pl0: got v=%b d=%h want 1 00000027", tag, pl_valid0, pl_data0); end
    step(crc, 1'b0);
    checks++; if (pl_valid0 !== 1'b1 || pl_data0 !== 32'h0) begin failures++; $display("FAIL %s_pl1: got v=%b d=%h want 1 00000000", tag, pl_valid0, pl_data0); end
    step(PEof, 1'b1);
    checks++; if (pl_valid0 !== 1'b0 || fdone0 !== 1'b0) begin failures++; $display("FAIL %s_eof: got v=%b done=%b want 0 0", tag, pl_valid0, fdone0); end
    step(PWtrm, 1'b1);
    checks++; if (fdone0 !== 1'b1 || fok0 !== !flip) begin failures++; $display("FAIL %s_done: got done=%b ok=%b want 1 %b", tag, fdone0, fok0, !flip); end
    checks++; if (tx_data0 !== (flip ? PRErr : PROk)) begin failures++; $display("FAIL %s_resp: got %h want %h", tag, tx_data0, flip ? PRErr : PROk); end
    step(PWtrm, 1'b1);
    checks++; if (fdone0 !== 1'b0 || tx_data0 !== (flip ? PRErr : PROk)) begin failures++; $display("FAIL %s_hold_resp: got done=%b tx=%h want 0 %h", tag, fdone0, tx_data0, flip ? PRErr : PROk); end
    step(PSync, 1'b1);
    checks++; if (tx_data0 !== PSync) begin failures++; $display("FAIL %s_idle: got %h want %h", tag, tx_data0, PSync); end
  endtask

  task automatic test_good_frame();
    run_small_frame(1'b0, "good");
  endtask

  task automatic test_bad_crc();
    run_small_frame(1'b1, "badcrc");
  endtask

  task automatic test_backpressure();
    logic [31:0] pay [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    logic [31:0] crc;
    crc = 32'h52325032;
    for (int i = 0; i < 5; i++) crc = crc_add(crc, pay[i]);
    frame_start();
    step(pay[0], 1'b0);
    step(pay[1], 1'b0);
    pl_ready = 1'b0;
    step(pay[2], 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (tx_data0 !== PHold || pl_valid0 !== 1'b1 || pl_data0 !== pay[0]) begin failures++; $display("FAIL bp_hold%0d: got tx=%h v=%b d=%h want %h 1 %h", i, tx_data0, pl_valid0, pl_data0, PHold, pay[0]); end
      if (i < 4) step(PHolda, 1'b1);
    end
    pl_ready = 1'b1;
    step(PHolda, 1'b1);
    checks++; if (tx_data0 !== PRIp || pl_data0 !== pay[1]) begin failures++; $display("FAIL bp_resume: got tx=%h d=%h want %h %h", tx_data0, pl_data0, PRIp, pay[1]); end
    step(pay[3], 1'b0);
    step(pay[4], 1'b0);
    step(crc, 1'b0);
    step(PEof, 1'b1);
    step(PWtrm, 1'b1);
    checks++; if (fdone0 !== 1'b1 || fok0 !== 1'b1) begin failures++; $display("FAIL bp_done: got done=%b ok=%b want 1 1", fdone0, fok0); end
    checks++; if (got0.size() != 5) begin failures++; $display("FAIL bp_count: got %0d want 5", got0.size()); end
    for (int i = 0; i < 5 && i < got0.size(); i++) begin
      checks++; if (got0[i] !== pay[i]) begin failures++; $display("FAIL bp_order%0d: got %h want %h", i, got0[i], pay[i]); end
    end
    step(PSync, 1'b1);
  endtask

  task automatic test_host_hold();
    logic [31:0] pay [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    logic [31:0] crc;
    crc = 32'h52325032;
    for (int i = 0; i < 4; i++) crc = crc_add(crc, pay[i]);
    frame_start();
    step(pay[0], 1'b0);
    step(pay[1], 1'b0);
    step(PHold, 1'b1);
    checks++; if (tx_data0 !== PHolda) begin failures++; $display("FAIL hh_holda0: got %h want %h", tx_data0, PHolda); end
    step(PHold, 1'b1);
    checks++; if (tx_data0 !== PHolda) begin failures++; $display("FAIL hh_holda1: got %h want %h", tx_data0, PHolda); end
    step(PAlign, 1'b1);
    step(PAlign, 1'b1);
    checks++; if (tx_data0 !== PHolda) begin failures++; $display("FAIL hh_align: got %h want %h", tx_data0, PHolda); end
    step(PHold, 1'b1);
    checks++; if (tx_data0 !== PHolda) begin failures++; $display("FAIL hh_holda2: got %h want %h", tx_data0, PHolda); end
    step(pay[2], 1'b0);
    checks++; if (tx_data0 !== PRIp || pl_data0 !== pay[1]) begin failures++; $display("FAIL hh_resume: got tx=%h d=%h want %h %h", tx_data0, pl_data0, PRIp, pay[1]); end
    step(pay[3], 1'b0);
    step(crc, 1'b0);
    step(PEof, 1'b1);
    step(PWtrm, 1'b1);
    checks++; if (fdone0 !== 1'b1 || fok0 !== 1'b1) begin failures++; $display("FAIL hh_done: got done=%b ok=%b want 1 1", fdone0, fok0); end
    checks++; if (got0.size() != 4) begin failures++; $display("FAIL hh_count: got %0d want 4", got0.size()); end
    for (int i = 0; i < 4 && i < got0.size(); i++) begin
      checks++; if (got0[i] !== pay[i]) begin failures++; $display("FAIL hh_order%0d: got %h want %h", i, got0[i], pay[i]); end
    end
    step(PSync, 1'b1);
  endtask

  task automatic test_overflow();
    logic [31:0] pay [6] = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06};
    logic [31:0] crc;
    crc = 32'h52325032;
    for (int i = 0; i < 6; i++) crc = crc_add(crc, pay[i]);
    frame_start();
    for (int i = 0; i < 6; i++) step(pay[i], 1'b0);
    checks++; if (pl_valid4 !== 1'b0) begin failures++; $display("FAIL ov_stop: got v=%b want 0", pl_valid4); end
    step(crc, 1'b0);
    step(PEof, 1'b1);
    step(PWtrm, 1'b1);
    checks++; if (fdone4 !== 1'b1 || fok4 !== 1'b0) begin failures++; $display("FAIL ov_done: got done=%b ok=%b want 1 0", fdone4, fok4); end
    checks++; if (tx_data4 !== PRErr) begin failures++; $display("FAIL ov_resp: got %h want %h", tx_data4, PRErr); end
    checks++; if (fok0 !== 1'b1) begin failures++; $display("FAIL ov_big_ok: got ok=%b want 1", fok0); end
    checks++; if (got4.size() != 4) begin failures++; $display("FAIL ov_count: got %0d want 4", got4.size()); end
    for (int i = 0; i < 4 && i < got4.size(); i++) begin
      checks++; if (got4[i] !== pay[i]) begin failures++; $display("FAIL ov_order%0d: got %h want %h", i, got4[i], pay[i]); end
    end
    step(PSync, 1'b1);
  endtask

  task automatic test_empty_frame();
    frame_start();
    step(PEof, 1'b1);
    step(PWtrm, 1'b1);
    checks++; if (fdone0 !== 1'b1 || fok0 !== 1'b0 || tx_data0 !== PRErr) begin failures++; $display("FAIL empty: got done=%b ok=%b tx=%h want 1 0 %h", fdone0, fok0, tx_data0, PRErr); end
    step(PSync, 1'b1);
  endtask

  task automatic test_abort();
    frame_start();
    step(32'hCAFE0001, 1'b0);
    step(32'hCAFE0002, 1'b0);
    step(PSync, 1'b1);
    checks++; if (fdone0 !== 1'b1 || fok0 !== 1'b0) begin failures++; $display("FAIL abort_done: got done=%b ok=%b want 1 0", fdone0, fok0); end
    checks++; if (pl_valid0 !== 1'b0 || tx_data0 !== PSync) begin failures++; $display("FAIL abort_idle: got v=%b tx=%h want 0 %h", pl_valid0, tx_data0, PSync); end
    step(PSync, 1'b1);
    checks++; if (fdone0 !== 1'b0) begin failures++; $display("FAIL abort_pulse: got done=%b want 0", fdone0); end
  endtask

  task automatic test_mid_reset();
    frame_start();
    step(32'hBEEF0001, 1'b0);
    step(32'hBEEF0002, 1'b0);
    checks++; if (pl_valid0 !== 1'b1 || pl_data0 !== 32'hBEEF0001) begin failures++; $display("FAIL mr_pre: got v=%b d=%h want 1 beef0001", pl_valid0, pl_data0); end
    rst = 1'b1;
    step(32'hBEEF0003, 1'b0);
    checks++; if (tx_data0 !== PSync || tx_k0 !== 1'b1) begin failures++; $display("FAIL mr_tx: got %h k=%b want %h 1", tx_data0, tx_k0, PSync); end
    checks++; if (pl_valid0 !== 1'b0 || pl_data0 !== 32'h0) begin failures++; $display("FAIL mr_pl: got v=%b d=%h want 0 0", pl_valid0, pl_data0); end
    checks++; if (fdone0 !== 1'b0 || fok0 !== 1'b0) begin failures++; $display("FAIL mr_frame: got done=%b ok=%b want 0 0", fdone0, fok0); end
    rst = 1'b0;
    step(PSync, 1'b1);
    checks++; if (fdone0 !== 1'b0 || tx_data0 !== PSync) begin failures++; $display("FAIL mr_after: got done=%b tx=%h want 0 %h", fdone0, tx_data0, PSync); end
    step(PXRdy, 1'b1);
    checks++; if (tx_data0 !== PRRdy) begin failures++; $display("FAIL mr_idle: got %h want %h", tx_data0, PRRdy); end
    step(PSync, 1'b1);
  endtask

  initial begin
    rx_data    = PSync;
    rx_charisk = 4'b0001;
    pl_ready   = 1'b1;
    rst        = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_backpressure();
    test_host_hold();
    test_overflow();
    test_empty_frame();
    test_abort();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
